// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, forwarding sources, and ALU/MEM-side outputs.
// The slave modport is the stage itself; master is whoever drives ID and observes EX.
interface id_ex_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RADDR = 5
);
    logic             stall;
    logic             flush;
    logic             id_valid;
    logic [3:0]       id_ALU_control;
    logic [XLEN-1:0]  id_rs_data;
    logic [XLEN-1:0]  id_rt_data;
    logic [15:0]      id_imm;
    logic [4:0]       id_shamt;
    logic [RADDR-1:0] id_rs;
    logic [RADDR-1:0] id_rt;
    logic [RADDR-1:0] id_dest;
    logic             id_alu_src;
    logic             id_sign_ext;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_mem_write;
    logic             exmem_reg_write;
    logic [RADDR-1:0] exmem_dest;
    logic [XLEN-1:0]  exmem_result;
    logic             memwb_reg_write;
    logic [RADDR-1:0] memwb_dest;
    logic [XLEN-1:0]  memwb_result;

    logic [3:0]       ALU_control;
    logic [XLEN-1:0]  in1_ALU;
    logic [XLEN-1:0]  in2_ALU;
    logic [4:0]       shamt;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_store_data;
    logic [RADDR-1:0] ex_dest;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             hazard_stall;

    modport slave (
        input  stall, flush, id_valid, id_ALU_control, id_rs_data, id_rt_data, id_imm,
               id_shamt, id_rs, id_rt, id_dest, id_alu_src, id_sign_ext, id_reg_write,
               id_mem_read, id_mem_write, exmem_reg_write, exmem_dest, exmem_result,
               memwb_reg_write, memwb_dest, memwb_result,
        output ALU_control, in1_ALU, in2_ALU, shamt, ex_valid, ex_store_data, ex_dest,
               ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall
    );

    modport master (
        output stall, flush, id_valid, id_ALU_control, id_rs_data, id_rt_data, id_imm,
               id_shamt, id_rs, id_rt, id_dest, id_alu_src, id_sign_ext, id_reg_write,
               id_mem_read, id_mem_write, exmem_reg_write, exmem_dest, exmem_result,
               memwb_reg_write, memwb_dest, memwb_result,
        input  ALU_control, in1_ALU, in2_ALU, shamt, ex_valid, ex_store_data, ex_dest,
               ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// single-bubble load-use hazard detection, feeding the ALU and MEM stage.
module id_ex_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RADDR  = 5,
    parameter int unsigned FWD_EN = 1
) (
    input logic           clk,
    input logic           reset_n,
    id_ex_stage_if.slave  bus
);

    typedef struct packed {
        logic             valid;
        logic [3:0]       alu_control;
        logic [XLEN-1:0]  rs_data;
        logic [XLEN-1:0]  rt_data;
        logic [XLEN-1:0]  imm_ext;
        logic [4:0]       shamt;
        logic [RADDR-1:0] rs;
        logic [RADDR-1:0] rt;
        logic [RADDR-1:0] dest;
        logic             alu_src;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
    } ex_reg_t;

    ex_reg_t          r;
    ex_reg_t          cap_c;
    logic             hazard_c;
    logic [XLEN-1:0]  fwd_rs_c;
    logic [XLEN-1:0]  fwd_rt_c;

    // Youngest producer wins; register 0 is hard-wired and never forwarded.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RADDR-1:0] src,
        input logic [XLEN-1:0]  rf_data,
        input logic             em_we,
        input logic [RADDR-1:0] em_dest,
        input logic [XLEN-1:0]  em_res,
        input logic             mw_we,
        input logic [RADDR-1:0] mw_dest,
        input logic [XLEN-1:0]  mw_res
    );
        logic [XLEN-1:0] res;
        res = rf_data;
        if (FWD_EN != 0) begin
            if (em_we && (em_dest != '0) && (em_dest == src))
                res = em_res;
            else if (mw_we && (mw_dest != '0) && (mw_dest == src))
                res = mw_res;
        end
        return res;
    endfunction

    // Capture image of the ID stage, immediate extended up front.
    always_comb begin
        cap_c             = '0;
        cap_c.valid       = bus.id_valid;
        cap_c.alu_control = bus.id_ALU_control;
        cap_c.rs_data     = bus.id_rs_data;
        cap_c.rt_data     = bus.id_rt_data;
        cap_c.imm_ext     = bus.id_sign_ext ? XLEN'($signed(bus.id_imm)) : XLEN'(bus.id_imm);
        cap_c.shamt       = bus.id_shamt;
        cap_c.rs          = bus.id_rs;
        cap_c.rt          = bus.id_rt;
        cap_c.dest        = bus.id_dest;
        cap_c.alu_src     = bus.id_alu_src;
        cap_c.reg_write   = bus.id_reg_write;
        cap_c.mem_read    = bus.id_mem_read;
        cap_c.mem_write   = bus.id_mem_write;
    end

    // rt is compared even for immediate forms; a spurious bubble is cheaper than the logic.
    assign hazard_c = r.valid & r.mem_read & (r.dest != '0)
                    & ((r.dest == bus.id_rs) | (r.dest == bus.id_rt)) & bus.id_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r <= '0;
        end else if (bus.flush) begin
            r.valid     <= 1'b0;
            r.reg_write <= 1'b0;
            r.mem_read  <= 1'b0;
            r.mem_write <= 1'b0;
        end else if (!bus.stall) begin
            if (hazard_c) begin
                r.valid     <= 1'b0;
                r.reg_write <= 1'b0;
                r.mem_read  <= 1'b0;
                r.mem_write <= 1'b0;
            end else begin
                r <= cap_c;
            end
        end
    end

    always_comb begin
        fwd_rs_c = fwd_sel(r.rs, r.rs_data, bus.exmem_reg_write, bus.exmem_dest, bus.exmem_result,
                           bus.memwb_reg_write, bus.memwb_dest, bus.memwb_result);
        fwd_rt_c = fwd_sel(r.rt, r.rt_data, bus.exmem_reg_write, bus.exmem_dest, bus.exmem_result,
                           bus.memwb_reg_write, bus.memwb_dest, bus.memwb_result);
    end

    assign bus.ALU_control   = r.alu_control;
    assign bus.in1_ALU       = fwd_rs_c;
    assign bus.in2_ALU       = r.alu_src ? r.imm_ext : fwd_rt_c;
    assign bus.shamt         = r.shamt;
    assign bus.ex_valid      = r.valid;
    assign bus.ex_store_data = fwd_rt_c;
    assign bus.ex_dest       = r.dest;
    assign bus.ex_reg_write  = r.valid & r.reg_write;
    assign bus.ex_mem_read   = r.valid & r.mem_read;
    assign bus.ex_mem_write  = r.valid & r.mem_write;
    assign bus.hazard_stall  = hazard_c;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage sitting directly upstream of the ALU.
- Captures decoded instruction fields and register-file data each cycle and resolves EX/MEM and MEM/WB forwarding.
- Drives the ALU operands (ALU_control, in1_ALU, in2_ALU, shamt) plus the pass-through controls needed by the MEM stage.
- Detects load-use hazards and inserts one bubble per hazard.

Parameters:
- XLEN, 32, datapath width in bits.
- RADDR, 5, register-address width in bits.
- FWD_EN, 1, 1 enables forwarding muxes; 0 drives register-file data straight through (forward selects forced to 0).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  hold all stage registers (external freeze)
- flush  in  1  kill the instruction being captured (branch/jump taken)
- id_valid  in  1  ID holds a real instruction
- id_ALU_control  in  4  ALU opcode (0/1 add, 2 and, 3 nor, 4 or, 5 slt, 6 sltu, 7/8/11 shifts, 9/10 sub)
- id_rs_data, id_rt_data  in  XLEN  register-file read data
- id_imm  in  16  instruction immediate
- id_shamt  in  5  shift amount
- id_rs, id_rt, id_dest  in  RADDR  source and destination register numbers
- id_alu_src  in  1  1 selects extended immediate for in2_ALU
- id_sign_ext  in  1  1 sign-extends id_imm, 0 zero-extends
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- exmem_reg_write  in  1  EX/MEM writes a register
- exmem_dest  in  RADDR  EX/MEM destination register
- exmem_result  in  XLEN  EX/MEM forwarded value
- memwb_reg_write  in  1  MEM/WB writes a register
- memwb_dest  in  RADDR  MEM/WB destination register
- memwb_result  in  XLEN  MEM/WB forwarded value
- ALU_control  out  4  registered opcode
- in1_ALU, in2_ALU  out  XLEN  ALU operands after forwarding and immediate select
- shamt  out  5  registered shift amount
- ex_valid  out  1  EX holds a real instruction
- ex_store_data  out  XLEN  forwarded rt value for stores
- ex_dest  out  RADDR  registered destination register
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  control bits, gated by ex_valid
- hazard_stall  out  1  load-use hazard; upstream must hold PC and IF/ID

Behaviour:

Reset (reset_n=0, asynchronous):
- All stage registers clear to 0.
- Resulting outputs: ex_valid=0, ALU_control=0, shamt=0, ex_dest=0, all control bits 0, hazard_stall=0.
- in1_ALU, in2_ALU and ex_store_data are 0 unless a forward match from the upstream ports applies.
- Reset mid-operation discards the captured instruction; no partial state survives.

Register update, priority flush > stall > hazard_stall > load:
- flush: ex_valid<=0 and all control bits cleared; data fields are don't-care.
- stall (without flush): every register holds its value.
- hazard_stall (without stall or flush): bubble inserted; ex_valid<=0, controls 0.
- Otherwise: capture all id_* fields; ex_valid<=id_valid.

Load-use hazard:
- hazard_stall = ex_valid & ex_mem_read & (ex_dest!=0) & (ex_dest==id_rs | ex_dest==id_rt) & id_valid.
- Combinational; compares rt conservatively regardless of id_alu_src.
- Exactly one bubble per load-use pair. After the bubble, the MEM/WB forward supplies the data.

Forwarding (combinational from registered rs/rt, evaluated per operand):
- sel=EX/MEM when exmem_reg_write & exmem_dest!=0 & exmem_dest==ex_rs.
- Else sel=MEM/WB when memwb_reg_write & memwb_dest!=0 & memwb_dest==ex_rs.
- Else the registered register-file data.
- EX/MEM has priority when both stages match. Register 0 is never forwarded.
- The same rule applies to rt and produces fwd_rt.

Operand and output drive:
- in1_ALU = fwd_rs.
- in2_ALU = ex_alu_src ? imm_ext : fwd_rt.
- ex_store_data = fwd_rt in all cases.
- imm_ext = sign_ext ? {{16{imm[15]}},imm} : {16'h0,imm}, computed at capture.
- Latency: one cycle from ID capture to valid ALU operands; forwarding adds no cycle.
- ex_reg_write, ex_mem_read and ex_mem_write are ANDed with ex_valid, so a bubble never writes.

Test Plan:
- Reset then id_valid=1, ALU_control=0, rs_data=5, rt_data=7, alu_src=0 -> next cycle ALU_control=0, in1_ALU=5, in2_ALU=7, ex_valid=1.
- id_imm=16'hFFFC, alu_src=1: with sign_ext=1 -> in2_ALU=32'hFFFFFFFC; with sign_ext=0 -> 32'h0000FFFC.
- Registered rs=3; exmem_dest=3 result=0x11; memwb_dest=3 result=0x22; both reg_write=1 -> in1_ALU=0x11. Drop exmem_reg_write -> in1_ALU=0x22. Set dest=0 on both -> register-file value.
- EX holds a load to r4 (mem_read=1) while ID has rs=4 -> hazard_stall=1. Next edge ex_valid=0 with ex_reg_write=0. Then with memwb_dest=4 result=0x99 the instruction issues with in1_ALU=0x99.
- stall=1 for 3 cycles with changing id_* inputs -> all outputs constant. Assert flush together with stall -> ex_valid=0 next edge.
- reset_n low asynchronously mid-cycle while ex_valid=1 -> outputs clear immediately without a clock edge.
